// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Pong match sequencer: frame tick, match FSM, strobes and scores.
// Revision : 1.0
// ============================================================================

module pong_game_ctrl #(
  parameter int ACTIVE_COLS  = 640,
  parameter int ACTIVE_ROWS  = 480,
  parameter int BALL_FRAMES  = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [9:0] i_Col_Count,
  input  logic [9:0] i_Row_Count,
  input  logic       i_Start,
  input  logic       i_Miss_P1,
  input  logic       i_Miss_P2,
  output logic       o_Ball_En,
  output logic       o_Paddle_En,
  output logic       o_Ball_Reset,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic [2:0] o_State,
  output logic [1:0] o_Winner
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SERVE = 3'd1;
  localparam logic [2:0] c_PLAY  = 3'd2;
  localparam logic [2:0] c_POINT = 3'd3;
  localparam logic [2:0] c_OVER  = 3'd4;

  localparam int c_CNT_MAX = (SERVE_FRAMES > BALL_FRAMES) ? SERVE_FRAMES : BALL_FRAMES;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_SERVE_LAST = c_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [c_CNT_W-1:0] c_BALL_LAST  = c_CNT_W'(BALL_FRAMES - 1);
  localparam logic [3:0]         c_WIN        = 4'(WIN_SCORE);
  localparam logic [9:0]         c_TICK_ROW   = 10'(ACTIVE_ROWS);

  logic [2:0]         r_State;
  logic [c_CNT_W-1:0] r_Frame_Cnt;
  logic               r_Start_d;
  logic               r_Start_Armed;
  logic               r_Ball_En;
  logic               r_Paddle_En;
  logic               r_Ball_Reset;
  logic [3:0]         r_Score_P1;
  logic [3:0]         r_Score_P2;
  logic [1:0]         r_Winner;

  logic               w_Frame_Tick;
  logic               w_Start_Edge;
  logic               w_Miss_Any;
  logic [2:0]         w_State_Nxt;
  logic [c_CNT_W-1:0] w_Cnt_Nxt;
  logic [3:0]         w_P1_Nxt;
  logic [3:0]         w_P2_Nxt;
  logic [1:0]         w_Winner_Nxt;
  logic               w_Ball_En_Nxt;

  // First blanking line, column 0: exactly one cycle per frame.
  assign w_Frame_Tick = (ACTIVE_COLS > 0) && (i_Row_Count == c_TICK_ROW) && (i_Col_Count == 10'd0);
  // Armed only after i_Start is seen low, so a switch held through reset cannot start a match.
  assign w_Start_Edge = i_Start & ~r_Start_d & r_Start_Armed;
  assign w_Miss_Any   = i_Miss_P1 | i_Miss_P2;

  always_comb begin
    w_State_Nxt   = r_State;
    w_Cnt_Nxt     = r_Frame_Cnt;
    w_P1_Nxt      = r_Score_P1;
    w_P2_Nxt      = r_Score_P2;
    w_Winner_Nxt  = r_Winner;
    w_Ball_En_Nxt = 1'b0;
    case (r_State)
      c_IDLE: begin
        if (w_Start_Edge) begin
          w_State_Nxt = c_SERVE;
          w_Cnt_Nxt   = '0;
        end
      end
      c_SERVE: begin
        if (w_Frame_Tick) begin
          if (r_Frame_Cnt == c_SERVE_LAST) begin
            w_Cnt_Nxt   = '0;
            w_State_Nxt = c_PLAY;
          end else begin
            w_Cnt_Nxt = r_Frame_Cnt + 1'b1;
          end
        end
      end
      c_PLAY: begin
        // A miss pre-empts any ball step due on the same cycle.
        if (w_Miss_Any) begin
          w_State_Nxt = c_POINT;
          if (i_Miss_P1 && !i_Miss_P2 && (r_Score_P2 != 4'hF))
            w_P2_Nxt = r_Score_P2 + 4'd1;
          if (i_Miss_P2 && !i_Miss_P1 && (r_Score_P1 != 4'hF))
            w_P1_Nxt = r_Score_P1 + 4'd1;
        end else if (w_Frame_Tick) begin
          if (r_Frame_Cnt == c_BALL_LAST) begin
            w_Cnt_Nxt     = '0;
            w_Ball_En_Nxt = 1'b1;
          end else begin
            w_Cnt_Nxt = r_Frame_Cnt + 1'b1;
          end
        end
      end
      c_POINT: begin
        if (r_Score_P1 == c_WIN) begin
          w_Winner_Nxt = 2'b01;
          w_State_Nxt  = c_OVER;
        end else if (r_Score_P2 == c_WIN) begin
          w_Winner_Nxt = 2'b10;
          w_State_Nxt  = c_OVER;
        end else begin
          w_State_Nxt = c_SERVE;
          w_Cnt_Nxt   = '0;
        end
      end
      c_OVER: begin
        if (w_Start_Edge) begin
          w_P1_Nxt     = 4'd0;
          w_P2_Nxt     = 4'd0;
          w_Winner_Nxt = 2'b00;
          w_State_Nxt  = c_SERVE;
          w_Cnt_Nxt    = '0;
        end
      end
      default: begin
        w_State_Nxt = c_IDLE;
        w_Cnt_Nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State       <= c_IDLE;
      r_Frame_Cnt   <= '0;
      r_Start_d     <= 1'b0;
      r_Start_Armed <= 1'b0;
      r_Ball_En     <= 1'b0;
      r_Paddle_En   <= 1'b0;
      r_Ball_Reset  <= 1'b1;
      r_Score_P1    <= 4'd0;
      r_Score_P2    <= 4'd0;
      r_Winner      <= 2'b00;
    end else begin
      r_State       <= w_State_Nxt;
      r_Frame_Cnt   <= w_Cnt_Nxt;
      r_Start_d     <= i_Start;
      r_Start_Armed <= r_Start_Armed | ~i_Start;
      r_Ball_En     <= w_Ball_En_Nxt;
      r_Paddle_En   <= w_Frame_Tick && ((r_State == c_SERVE) || (r_State == c_PLAY));
      r_Ball_Reset  <= (w_State_Nxt != c_PLAY);
      r_Score_P1    <= w_P1_Nxt;
      r_Score_P2    <= w_P2_Nxt;
      r_Winner      <= w_Winner_Nxt;
    end
  end

  assign o_Ball_En    = r_Ball_En;
  assign o_Paddle_En  = r_Paddle_En;
  assign o_Ball_Reset = r_Ball_Reset;
  assign o_Score_P1   = r_Score_P1;
  assign o_Score_P2   = r_Score_P2;
  assign o_State      = r_State;
  assign o_Winner     = r_Winner;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Directed, self-checking bench for pong_game_ctrl with a match model.
// Revision : 1.0
// ============================================================================

module tb_pong_game_ctrl;

  localparam int c_SERVE = 4;
  localparam int c_BALL  = 2;
  localparam int c_WIN   = 3;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [9:0] i_Col_Count;
  logic [9:0] i_Row_Count;
  logic       i_Start;
  logic       i_Miss_P1;
  logic       i_Miss_P2;
  logic       o_Ball_En;
  logic       o_Paddle_En;
  logic       o_Ball_Reset;
  logic [3:0] o_Score_P1;
  logic [3:0] o_Score_P2;
  logic [2:0] o_State;
  logic [1:0] o_Winner;

  int n_checks = 0;
  int n_errors = 0;

  pong_game_ctrl #(
    .ACTIVE_COLS (640),
    .ACTIVE_ROWS (480),
    .BALL_FRAMES (c_BALL),
    .SERVE_FRAMES(c_SERVE),
    .WIN_SCORE   (c_WIN)
  ) u_dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Col_Count (i_Col_Count),
    .i_Row_Count (i_Row_Count),
    .i_Start     (i_Start),
    .i_Miss_P1   (i_Miss_P1),
    .i_Miss_P2   (i_Miss_P2),
    .o_Ball_En   (o_Ball_En),
    .o_Paddle_En (o_Paddle_En),
    .o_Ball_Reset(o_Ball_Reset),
    .o_Score_P1  (o_Score_P1),
    .o_Score_P2  (o_Score_P2),
    .o_State     (o_State),
    .o_Winner    (o_Winner)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Match model: m_state 0 idle, 1 serve, 2 play, 3 point, 4 over; m_ticks counts frames in the phase.
  int m_state = 0;
  int m_ticks = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  int m_win = 0;
  bit m_ben = 0;
  bit m_pen = 0;
  bit m_prev_start = 1;

  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      m_state = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_ben = 0; m_pen = 0; m_prev_start = 1;
    end else begin
      bit tick, sedge, ben;
      tick  = (i_Row_Count == 10'd480) && (i_Col_Count == 10'd0);
      sedge = i_Start && !m_prev_start;
      m_prev_start = i_Start;
      ben   = 0;
      m_pen = tick && (m_state == 1 || m_state == 2);
      case (m_state)
        0: if (sedge) begin m_state = 1; m_ticks = 0; end
        1: if (tick) begin
             m_ticks++;
             if (m_ticks == c_SERVE) begin m_state = 2; m_ticks = 0; end
           end
        2: if (i_Miss_P1 || i_Miss_P2) begin
             if (i_Miss_P1 && !i_Miss_P2) m_s2++;
             if (i_Miss_P2 && !i_Miss_P1) m_s1++;
             m_state = 3;
           end else if (tick) begin
             m_ticks++;
             if (m_ticks == c_BALL) begin m_ticks = 0; ben = 1; end
           end
        3: if (m_s1 == c_WIN) begin m_win = 1; m_state = 4; end
           else if (m_s2 == c_WIN) begin m_win = 2; m_state = 4; end
           else begin m_state = 1; m_ticks = 0; end
        4: if (sedge) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_state = 1; m_ticks = 0; end
        default: m_state = 0;
      endcase
      m_ben = ben;
    end
  end

  always @(posedge i_Clk) begin
    #2;
    chk("cycle", {16'd0, o_Ball_En, o_Paddle_En, o_Ball_Reset, o_Score_P1, o_Score_P2, o_State, o_Winner},
                 {16'd0, m_ben, m_pen, (m_state != 2), 4'(m_s1), 4'(m_s2), 3'(m_state), 2'(m_win)});
  end

  bit count_en = 0;
  int n_ben = 0;
  int n_pen = 0;
  always @(posedge i_Clk) begin
    #2;
    if (!count_en) begin
      n_ben = 0; n_pen = 0;
    end else begin
      if (o_Ball_En) n_ben++;
      if (o_Paddle_En) n_pen++;
    end
  end

  // One frame: tick cycle followed by near-miss decode vectors.
  task automatic frame();
    @(negedge i_Clk); i_Row_Count = 10'd480; i_Col_Count = 10'd0;
    @(negedge i_Clk); i_Row_Count = 10'd480; i_Col_Count = 10'd1;
    @(negedge i_Clk); i_Row_Count = 10'd479; i_Col_Count = 10'd0;
    @(negedge i_Clk); i_Row_Count = 10'd0;   i_Col_Count = 10'd0;
    @(negedge i_Clk); i_Row_Count = 10'd100; i_Col_Count = 10'd300;
    @(negedge i_Clk); i_Row_Count = 10'd0;   i_Col_Count = 10'd5;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic miss(input bit p1, input bit p2, input bit on_tick);
    @(negedge i_Clk);
    i_Miss_P1 = p1; i_Miss_P2 = p2;
    if (on_tick) begin i_Row_Count = 10'd480; i_Col_Count = 10'd0; end
    else begin i_Row_Count = 10'd0; i_Col_Count = 10'd7; end
    @(negedge i_Clk);
    i_Miss_P1 = 1'b0; i_Miss_P2 = 1'b0; i_Row_Count = 10'd0; i_Col_Count = 10'd7;
  endtask

  task automatic press();
    @(negedge i_Clk); i_Start = 1'b0;
    @(negedge i_Clk); i_Start = 1'b1;
    @(negedge i_Clk); i_Start = 1'b0;
  endtask

  initial begin
    i_Rst_L = 1'b0; i_Start = 1'b0; i_Miss_P1 = 1'b0; i_Miss_P2 = 1'b0;
    i_Row_Count = 10'd0; i_Col_Count = 10'd0;
    repeat (3) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    chk("rst_state", o_State, 0);
    chk("rst_ball_reset", o_Ball_Reset, 1);
    chk("rst_outputs", {o_Ball_En, o_Paddle_En, o_Score_P1, o_Score_P2, o_Winner}, 0);

    // Reset then start, serve length
    frames(2);
    press();
    chk("start_serve", o_State, 1);
    frames(3);
    chk("serve_hold", o_State, 1);
    frame();
    chk("serve_to_play", o_State, 2);
    chk("play_ball_reset", o_Ball_Reset, 0);

    // Ball and paddle cadence over 10 frames
    count_en = 1;
    frames(10);
    @(negedge i_Clk);
    chk("ball_pulses", n_ben, 5);
    chk("paddle_pulses", n_pen, 10);
    count_en = 0;

    // P1 miss scores for P2
    miss(1, 0, 0);
    chk("miss_point_state", o_State, 3);
    chk("miss_scores", {o_Score_P1, o_Score_P2}, 8'h01);
    @(posedge i_Clk); #3;
    chk("point_to_serve", o_State, 1);

    // Simultaneous miss replays rally
    frames(4);
    chk("replay_play", o_State, 2);
    miss(1, 1, 0);
    chk("both_point", o_State, 3);
    chk("both_scores", {o_Score_P1, o_Score_P2}, 8'h01);
    @(posedge i_Clk); #3;
    chk("both_serve", o_State, 1);

    // Async reset mid-PLAY, start held through release
    frames(5);
    @(posedge i_Clk); #3;
    i_Rst_L = 1'b0;
    #1;
    chk("async_rst", {o_Ball_En, o_Paddle_En, o_Ball_Reset, o_Score_P1, o_Score_P2, o_State, o_Winner},
                     {1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 2'd0});
    @(negedge i_Clk); i_Start = 1'b1;
    @(negedge i_Clk); i_Rst_L = 1'b1;
    frames(2);
    chk("held_start_ignored", o_State, 0);
    press();
    chk("repress_start", o_State, 1);

    // Three P1 misses give P2 the match; last miss lands on a ball-step tick
    for (int r = 0; r < 3; r++) begin
      frames(5);
      miss(1, 0, r == 2);
    end
    chk("win_point", {o_State, o_Score_P2}, {3'd3, 4'd3});
    @(posedge i_Clk); #3;
    chk("win_over", o_State, 4);
    chk("win_winner", o_Winner, 2);
    miss(1, 0, 0);
    miss(0, 1, 0);
    chk("over_ignore_miss", {o_Score_P1, o_Score_P2, o_State}, {4'd0, 4'd3, 3'd4});
    press();
    chk("restart", {o_Score_P1, o_Score_P2, o_Winner, o_State}, {4'd0, 4'd0, 2'd0, 3'd1});
    frames(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
